// File: rtl/hazard_if.sv
// Hazard-control bundle between the pipeline (master side) and hazard_ctrl (slave side).
// The master drives the ID/EX hazard inputs and reads the pipeline controls.
interface hazard_if;
  logic [4:0]  rs_num_ID;
  logic [4:0]  rt_num_ID;
  logic        uses_rt_ID;
  logic        mem_read_EX;
  logic [4:0]  rt_num_EX;
  logic        branch_taken_EX;
  logic        mdu_op_EX;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_bubble;
  logic        mdu_start;
  logic        mdu_result_valid;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output rs_num_ID, rt_num_ID, uses_rt_ID, mem_read_EX, rt_num_EX,
           branch_taken_EX, mdu_op_EX,
    input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
           exmem_bubble, mdu_start, mdu_result_valid, stall_cycles, flush_count
  );

  modport slave (
    input  rs_num_ID, rt_num_ID, uses_rt_ID, mem_read_EX, rt_num_EX,
           branch_taken_EX, mdu_op_EX,
    output pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
           exmem_bubble, mdu_start, mdu_result_valid, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and MDU occupancy of EX.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 4,  // legal range 2..16
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  hazard_if.slave    hif,
  output logic [1:0] state_dbg
);
  // There is no valid/ready handshake here: every input is a level sampled each
  // cycle, and every output is a level that is valid for the current cycle only.

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;

  logic pc_write, ifid_write, idex_write;
  logic ifid_flush, idex_flush, exmem_bubble;
  logic mdu_start, mdu_result_valid;

  assign load_use = hif.mem_read_EX && (hif.rt_num_EX != 5'd0) &&
                    ((hif.rt_num_EX == hif.rs_num_ID) ||
                     (hif.uses_rt_ID && (hif.rt_num_EX == hif.rt_num_ID)));

  // BUSY lasts MDU_LATENCY-1 cycles: the counter runs CNT_INIT down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hif.mdu_op_EX) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_write         = 1'b1;
    ifid_write       = 1'b1;
    idex_write       = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    exmem_bubble     = 1'b0;
    mdu_start        = 1'b0;
    mdu_result_valid = 1'b0;
    if (!rst) begin
      if ((state == BUSY) || ((state == RUN) && hif.mdu_op_EX)) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        mdu_start    = (state == RUN);
      end else begin
        // DONE still sees mdu_op_EX high for the finishing op; it must not restart.
        mdu_result_valid = (state == DONE);
        if (hif.branch_taken_EX) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  assign hif.pc_write         = pc_write;
  assign hif.ifid_write       = ifid_write;
  assign hif.idex_write       = idex_write;
  assign hif.ifid_flush       = ifid_flush;
  assign hif.idex_flush       = idex_flush;
  assign hif.exmem_bubble     = exmem_bubble;
  assign hif.mdu_start        = mdu_start;
  assign hif.mdu_result_valid = mdu_result_valid;
  assign state_dbg            = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write)  stall_q <= stall_q + 32'd1;
      if (ifid_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
`else
  assign hif.stall_cycles = '0;
  assign hif.flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against an
// age-based reference model of the MDU occupancy and the hazard rules.
module tb_hazard_ctrl;
  localparam int L = 4;

  typedef struct packed {
    logic       r;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mr;
    logic [4:0] rte;
    logic       br;
    logic       mdu;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  hazard_if   hif ();

  hazard_ctrl #(.MDU_LATENCY(L), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hif       (hif),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: age = cycles since mdu_start (-1 when no MDU op is live).
  logic [7:0]  exp_q[$];
  int          age      = -1;
  int          age_nxt  = -1;
  bit          pend_ok  = 1'b0;
  logic        pend_rst = 1'b1;
  logic        pend_pcw = 1'b1;
  logic        pend_iff = 1'b0;
  int unsigned m_stall  = 0;
  int unsigned m_flush  = 0;

  function automatic stim_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic urt,
                               logic mr, logic [4:0] rte, logic br, logic mdu);
    stim_t s;
    s = '{r: r, rs: rs, rt: rt, urt: urt, mr: mr, rte: rte, br: br, mdu: mdu};
    return s;
  endfunction

  function automatic logic [7:0] observed();
    return {hif.pc_write, hif.ifid_write, hif.idex_write, hif.ifid_flush,
            hif.idex_flush, hif.exmem_bubble, hif.mdu_start, hif.mdu_result_valid};
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef HAZARD_PERF_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush();
`ifdef HAZARD_PERF_CNT_EN
    return m_flush;
`else
    return 32'd0;
`endif
  endfunction

  // Applies one cycle of stimulus and pushes the model's expected output vector
  // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_bubble, mdu_start, mdu_result_valid}.
  task automatic step(input stim_t s);
    logic [7:0] e;
    logic       lu;
    @(negedge clk);
    if (pend_ok) begin
      age = age_nxt;
      if (pend_rst) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!pend_pcw) m_stall++;
        if (pend_iff)  m_flush++;
      end
    end
    rst                 = s.r;
    hif.rs_num_ID       = s.rs;
    hif.rt_num_ID       = s.rt;
    hif.uses_rt_ID      = s.urt;
    hif.mem_read_EX     = s.mr;
    hif.rt_num_EX       = s.rte;
    hif.branch_taken_EX = s.br;
    hif.mdu_op_EX       = s.mdu;
    #1;
    lu = s.mr && (s.rte != 5'd0) && ((s.rte == s.rs) || (s.urt && (s.rte == s.rt)));
    e = 8'b1110_0000;
    age_nxt = -1;
    if (s.r) begin
      age_nxt = -1;
    end else if (age < 0 && s.mdu) begin
      e = 8'b0000_0110;
      age_nxt = 1;
    end else if (age >= 1 && age <= L - 1) begin
      e = 8'b0000_0100;
      age_nxt = age + 1;
    end else begin
      if (age == L) e[0] = 1'b1;
      if (s.br) begin
        e[4] = 1'b1;
        e[3] = 1'b1;
      end else if (lu) begin
        e[7] = 1'b0;
        e[6] = 1'b0;
        e[3] = 1'b1;
      end
    end
    pend_ok  = 1'b1;
    pend_rst = s.r;
    pend_pcw = e[7];
    pend_iff = e[4];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      step(mk(1, 5, 5, 1, 1, 5, 1, 1));
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) $display("FAIL reset_out[%0d] got %b exp %b", i, observed(), e);
      else n_pass++;
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front();
    n_checks++;
    if (observed() !== e) $display("FAIL reset_idle got %b exp %b", observed(), e);
    else n_pass++;
    n_checks++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_dbg);
    else n_pass++;
    n_checks++;
    if (hif.stall_cycles !== 32'd0 || hif.flush_count !== 32'd0)
      $display("FAIL reset_perf got %0d/%0d exp 0/0", hif.stall_cycles, hif.flush_count);
    else n_pass++;
  endtask

  task automatic run_table(input string name, input stim_t tbl[$]);
    logic [7:0] e;
    foreach (tbl[i]) begin
      step(tbl[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) $display("FAIL %s[%0d] got %b exp %b", name, i, observed(), e);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    t.push_back(mk(0, 5, 0, 0, 1, 5, 0, 0));  // hit on rs
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  // defaults next cycle
    t.push_back(mk(0, 3, 7, 1, 1, 7, 0, 0));  // hit on rt
    t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));  // $0 never stalls
    t.push_back(mk(0, 3, 5, 0, 1, 5, 0, 0));  // rt not a source
    t.push_back(mk(0, 5, 0, 0, 0, 5, 0, 0));  // not a load
    run_table("load_use", t);
  endtask

  task automatic test_mdu();
    stim_t t[$];
    for (int i = 0; i <= L; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("mdu", t);
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    for (int i = 0; i < 2 * (L + 1); i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(0, 4, 0, 0, 1, 4, 0, 0));
    run_table("back_to_back", t);
  endtask

  task automatic test_branch_priority();
    stim_t t[$];
    t.push_back(mk(0, 6, 0, 0, 1, 6, 1, 0));  // branch beats load-use
    t.push_back(mk(0, 6, 0, 0, 1, 6, 1, 1));  // MDU beats branch
    for (int i = 1; i < L; i++) t.push_back(mk(0, 6, 0, 0, 1, 6, 1, 1));
    t.push_back(mk(0, 6, 0, 0, 1, 6, 1, 1));  // DONE with branch
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("branch", t);
  endtask

  task automatic test_reset_mdu();
    stim_t t[$];
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));  // T
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));  // T+1
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));  // T+2 reset
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("reset_mdu", t);
    n_checks++;
    if (state_dbg !== 2'd0) $display("FAIL reset_mdu_state got %0d exp 0", state_dbg);
    else n_pass++;
    t.delete();
    for (int i = 0; i <= L; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("reset_mdu_restart", t);
  endtask

  task automatic test_perf();
    stim_t t[$];
    logic [31:0] es, ef;
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 5, 0, 0, 1, 5, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= L; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(0, 5, 0, 0, 1, 5, 1, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    run_table("perf", t);
`ifdef HAZARD_PERF_CNT_EN
    es = 32'd5;
    ef = 32'd1;
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    n_checks++;
    if (hif.stall_cycles !== es) $display("FAIL perf_stall got %0d exp %0d", hif.stall_cycles, es);
    else n_pass++;
    n_checks++;
    if (hif.flush_count !== ef) $display("FAIL perf_flush got %0d exp %0d", hif.flush_count, ef);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] e;
    stim_t      s;
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom_range(0, 59) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      step(s);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) $display("FAIL random_out[%0d] got %b exp %b", i, observed(), e);
      else n_pass++;
      n_checks++;
      if (hif.stall_cycles !== exp_stall() || hif.flush_count !== exp_flush())
        $display("FAIL random_perf[%0d] got %0d/%0d exp %0d/%0d", i, hif.stall_cycles,
                 hif.flush_count, exp_stall(), exp_flush());
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    hif.rs_num_ID       = '0;
    hif.rt_num_ID       = '0;
    hif.uses_rt_ID      = 1'b0;
    hif.mem_read_EX     = 1'b0;
    hif.rt_num_EX       = '0;
    hif.branch_taken_EX = 1'b0;
    hif.mdu_op_EX       = 1'b0;
    test_reset();
    test_load_use();
    test_mdu();
    test_back_to_back();
    test_branch_priority();
    test_reset_mdu();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
